// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch stage in front of the 128-entry
// instruction ROM. It supports start, stall, branch/jump redirect with
// wrong-path flush, and halt-opcode detection. It also keeps a saturating
// count of delivered instructions.
module fetch_unit #(
    parameter logic [6:0] START_ADDR  = 7'd0,
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic             redirect_abs_i,
    input  logic [6:0]       redirect_target_i,
    output logic [6:0]       rom_addr_o,
    input  logic [7:0]       rom_data_i,
    output logic [7:0]       instr_o,
    output logic [6:0]       instr_pc_o,
    output logic             instr_valid_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [6:0]       r_pc;
    logic [6:0]       w_pc_nxt;
    logic [7:0]       r_instr;
    logic [7:0]       w_instr_nxt;
    logic [6:0]       r_instr_pc;
    logic [6:0]       w_instr_pc_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Next-state and next-datapath decode; redirect beats stall, stall beats fetch.
    always_comb begin
        // NOTE: every target gets its hold value first, so no branch can leave a latch behind.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_count_nxt    = r_count;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_pc_nxt    = START_ADDR;
                    w_count_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (redirect_i) begin
                    if (redirect_abs_i) begin
                        w_pc_nxt = redirect_target_i;
                    end else begin
                        // A 7-bit add that wraps is the same as adding the
                        // sign-extended offset modulo 128.
                        w_pc_nxt = r_instr_pc + redirect_target_i;
                    end
                    w_valid_nxt = 1'b0;
                end else if (!stall_i) begin
                    w_instr_nxt    = rom_data_i;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    if (r_count != '1) begin
                        w_count_nxt = r_count + 1'b1;
                    end
                    if (rom_data_i == HALT_OPCODE) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt = r_pc + 7'd1;
                    end
                end
            end

            ST_HALTED: begin
                w_valid_nxt = 1'b0;
                if (start_i) begin
                    w_pc_nxt    = START_ADDR;
                    w_count_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: registers always use non-blocking assignments, so every flop samples pre-edge values.
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pc       <= START_ADDR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign rom_addr_o    = r_pc;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign instr_valid_o = r_valid;
    assign busy_o        = (r_state == ST_RUN);
    assign halted_o      = (r_state == ST_HALTED);
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: checks fetch_unit against a cycle-level behavioural model.
// The model pushes each delivered instruction into a scoreboard queue.
// A monitor on the falling edge pops that queue and compares status.
module tb_fetch_unit;

    localparam int         CNT_W   = 5;   // narrow so saturation is reachable
    localparam int         CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [7:0] HALT    = 8'hFF;
    localparam int         START   = 0;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic             stall_i = 1'b0;
    logic             redirect_i = 1'b0;
    logic             redirect_abs_i = 1'b0;
    logic [6:0]       redirect_target_i = '0;
    logic [6:0]       rom_addr_o;
    logic [7:0]       rom_data_i;
    logic [7:0]       instr_o;
    logic [6:0]       instr_pc_o;
    logic             instr_valid_o;
    logic             busy_o;
    logic             halted_o;
    logic [CNT_W-1:0] fetch_count_o;

    logic [7:0] rom [128];
    assign rom_data_i = rom[rom_addr_o];

    always #5 clk_i = ~clk_i;

    fetch_unit #(.START_ADDR(7'd0), .HALT_OPCODE(8'hFF), .CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_abs_i   (redirect_abs_i),
        .redirect_target_i(redirect_target_i),
        .rom_addr_o       (rom_addr_o),
        .rom_data_i       (rom_data_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_valid_o    (instr_valid_o),
        .busy_o           (busy_o),
        .halted_o         (halted_o),
        .fetch_count_o    (fetch_count_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int pc;
        int instr;
    } deliv_t;

    deliv_t exp_q[$];
    int m_state = M_IDLE;
    int m_pc = START;
    int m_last_pc = 0;
    int m_last_instr = 0;
    int m_count = 0;
    bit m_valid = 1'b0;

    always @(posedge clk_i) begin
        int d;
        if (reset_i) begin
            m_state = M_IDLE; m_pc = START; m_last_pc = 0;
            m_last_instr = 0; m_valid = 0; m_count = 0;
        end else if (m_state == M_IDLE) begin
            if (start_i) begin
                m_state = M_RUN; m_pc = START; m_count = 0;
            end
        end else if (m_state == M_RUN) begin
            if (redirect_i) begin
                if (redirect_abs_i) begin
                    m_pc = int'(redirect_target_i);
                end else begin
                    // Offset is signed 7-bit: subtract 128 when the top bit is set.
                    m_pc = (m_last_pc + int'(redirect_target_i) - (redirect_target_i[6] ? 128 : 0) + 128) % 128;
                end
                m_valid = 0;
            end else if (!stall_i) begin
                d = int'(rom[m_pc]);
                exp_q.push_back('{pc: m_pc, instr: d});
                m_last_pc = m_pc; m_last_instr = d; m_valid = 1;
                m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
                if (d == int'(HALT)) m_state = M_HALTED;
                else m_pc = (m_pc + 1) % 128;
            end
        end else begin
            m_valid = 0;
            if (start_i) begin
                m_state = M_RUN; m_pc = START; m_count = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        deliv_t e;
        if (mon_en) begin
            check("rom_addr", 32'(rom_addr_o), 32'(m_pc));
            check("busy", 32'(busy_o), 32'(m_state == M_RUN));
            check("halted", 32'(halted_o), 32'(m_state == M_HALTED));
            check("count", 32'(fetch_count_o), 32'(m_count));
            check("valid", 32'(instr_valid_o), 32'(m_valid));
            check("instr_pc_hold", 32'(instr_pc_o), 32'(m_last_pc));
            check("instr_hold", 32'(instr_o), 32'(m_last_instr));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("deliv_valid", 32'(instr_valid_o), 32'd1);
                check("deliv_pc", 32'(instr_pc_o), 32'(e.pc));
                check("deliv_instr", 32'(instr_o), 32'(e.instr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic set_in(bit rst, bit st, bit stl, bit rd, bit ab, logic [6:0] tg);
        reset_i = rst; start_i = st; stall_i = stl;
        redirect_i = rd; redirect_abs_i = ab; redirect_target_i = tg;
    endtask

    // kind 0: model pc == val; 1: delivered from val; 2: halted
    task automatic wait_for(int kind, int val);
        bit hit;
        for (int i = 0; i < 400; i++) begin
            tick();
            hit = (kind == 0) ? (m_pc == val && m_state == M_RUN) :
                  (kind == 1) ? (m_valid && m_last_pc == val) :
                                (m_state == M_HALTED);
            if (hit) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_for kind %0d val %0h: timed out", kind, val);
    endtask

    initial begin
        int cnt_before;
        for (int i = 0; i < 128; i++) rom[i] = (i < 6) ? 8'(i) : HALT;

        // Reset values
        tick(); tick();
        mon_en = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("rst_instr", 32'(instr_o), 0);
        check("rst_instr_pc", 32'(instr_pc_o), 0);
        check("rst_valid", 32'(instr_valid_o), 0);
        check("rst_count", 32'(fetch_count_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rom_addr", 32'(rom_addr_o), 0);

        // Identity program with halt at address 6
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        check("halt_instr", 32'(instr_o), 32'hFF);
        check("halt_instr_pc", 32'(instr_pc_o), 6);
        check("halt_valid", 32'(instr_valid_o), 1);
        tick();
        check("halted_flag", 32'(halted_o), 1);
        check("halted_valid", 32'(instr_valid_o), 0);
        check("halted_count", 32'(fetch_count_o), 7);

        // Stall at pc 3, restarting from HALTED
        for (int i = 0; i < 128; i++) rom[i] = 8'(i);
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        wait_for(0, 3);
        set_in(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rom_addr", 32'(rom_addr_o), 3);
            check("stall_instr_pc", 32'(instr_pc_o), 2);
            check("stall_count", 32'(fetch_count_o), 3);
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("resume_instr", 32'(instr_o), 3);

        // Relative redirect by -4 from instr_pc 10
        wait_for(1, 10);
        set_in(0, 0, 0, 1, 0, 7'h7C);
        tick();
        check("rel_flush_valid", 32'(instr_valid_o), 0);
        check("rel_pc", 32'(rom_addr_o), 6);
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("rel_instr_pc", 32'(instr_pc_o), 6);

        // Absolute redirect to 0x40
        set_in(0, 0, 0, 1, 1, 7'h40);
        tick();
        check("abs_flush_valid", 32'(instr_valid_o), 0);
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("abs_instr_pc", 32'(instr_pc_o), 32'h40);

        // Redirect + stall while a halt opcode is on the ROM bus
        rom[8'h50] = HALT;
        wait_for(0, 32'h50);
        cnt_before = m_count;
        set_in(0, 0, 1, 1, 1, 7'h10);
        tick();
        check("rs_no_halt", 32'(halted_o), 0);
        check("rs_valid", 32'(instr_valid_o), 0);
        check("rs_count", 32'(fetch_count_o), 32'(cnt_before));
        check("rs_pc", 32'(rom_addr_o), 32'h10);
        rom[8'h50] = 8'h50;

        // Wrap from 0x7E through 0x00
        set_in(0, 0, 0, 1, 1, 7'h7E);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("wrap_7e", 32'(instr_pc_o), 32'h7E);
        tick();
        check("wrap_7f", 32'(instr_pc_o), 32'h7F);
        check("wrap_7f_valid", 32'(instr_valid_o), 1);
        tick();
        check("wrap_00", 32'(instr_pc_o), 0);
        check("wrap_00_valid", 32'(instr_valid_o), 1);
        check("count_saturated", 32'(fetch_count_o), CNT_MAX);

        // Reset (with start) mid-run at pc 0x20
        wait_for(0, 32'h20);
        set_in(1, 1, 0, 0, 0, 0);
        tick();
        check("mrst_busy", 32'(busy_o), 0);
        check("mrst_valid", 32'(instr_valid_o), 0);
        check("mrst_rom_addr", 32'(rom_addr_o), 0);
        check("mrst_instr_pc", 32'(instr_pc_o), 0);
        check("mrst_count", 32'(fetch_count_o), 0);
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        check("mrst_idle", 32'(busy_o), 0);

        // Halt, then restart from HALTED
        rom[3] = HALT;
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        wait_for(2, 0);
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        check("restart_busy", 32'(busy_o), 1);
        check("restart_count", 32'(fetch_count_o), 0);
        check("restart_pc", 32'(rom_addr_o), 0);
        tick();
        check("restart_first", 32'(instr_o), 0);
        check("restart_cnt1", 32'(fetch_count_o), 1);

        // Randomized phase
        for (int i = 0; i < 128; i++) rom[i] = ($urandom_range(0, 11) == 0) ? HALT : 8'($urandom_range(0, 254));
        for (int c = 0; c < 4000; c++) begin
            tick();
            set_in($urandom_range(0, 99) == 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0,
                   1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)));
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
